// File: rtl/mips_core_pkg.sv
// Shared core types: physical-register tags, active-list ids and the
// issue-queue entry record used by the scheduler.
package mips_core_pkg;

    localparam int PHYS_REG_NUM_INDEX     = 6;
    localparam int ACTIVE_LIST_SIZE_INDEX = 5;

    typedef logic [PHYS_REG_NUM_INDEX-1:0]     phys_tag_t;
    typedef logic [ACTIVE_LIST_SIZE_INDEX-1:0] al_id_t;

    // Payload is kept outside the struct so its width can stay a module parameter.
    typedef struct packed {
        logic      valid;
        phys_tag_t src1;
        logic      src1_rdy;
        phys_tag_t src2;
        logic      src2_rdy;
        al_id_t    al_id;
    } iq_entry_t;

endpackage

// File: rtl/param_issue_queue_if.sv
// Dispatch / wakeup / issue bundle of the issue queue. master = rename and
// execute side, slave = the queue.
interface param_issue_queue_if #(
    parameter int DEPTH      = 8,
    parameter int DISPATCH_W = 2,
    parameter int WB_PORTS   = 2,
    parameter int PAYLOAD_W  = 64
);
    // Handshakes: dispatch transfers all valid lanes in a cycle with disp_ready=1
    // (all-or-nothing); issue transfers on a cycle with iss_valid=1 and iss_ready=1.
    logic [DISPATCH_W-1:0]                            disp_valid;
    mips_core_pkg::phys_tag_t [DISPATCH_W-1:0]        disp_src1;
    mips_core_pkg::phys_tag_t [DISPATCH_W-1:0]        disp_src2;
    logic [DISPATCH_W-1:0]                            disp_src1_rdy;
    logic [DISPATCH_W-1:0]                            disp_src2_rdy;
    mips_core_pkg::al_id_t [DISPATCH_W-1:0]           disp_al_id;
    logic [DISPATCH_W-1:0][PAYLOAD_W-1:0]             disp_payload;
    logic                                             disp_ready;
    logic [WB_PORTS-1:0]                              wb_valid;
    mips_core_pkg::phys_tag_t [WB_PORTS-1:0]          wb_tag;
    logic                                             flush;
    logic                                             iss_valid;
    logic                                             iss_ready;
    mips_core_pkg::phys_tag_t                         iss_src1;
    mips_core_pkg::phys_tag_t                         iss_src2;
    mips_core_pkg::al_id_t                            iss_al_id;
    logic [PAYLOAD_W-1:0]                             iss_payload;
    logic [$clog2(DEPTH+1)-1:0]                       free_count;

    modport master (
        output disp_valid, disp_src1, disp_src2, disp_src1_rdy, disp_src2_rdy,
               disp_al_id, disp_payload, wb_valid, wb_tag, flush, iss_ready,
        input  disp_ready, iss_valid, iss_src1, iss_src2, iss_al_id, iss_payload,
               free_count
    );

    modport slave (
        input  disp_valid, disp_src1, disp_src2, disp_src1_rdy, disp_src2_rdy,
               disp_al_id, disp_payload, wb_valid, wb_tag, flush, iss_ready,
        output disp_ready, iss_valid, iss_src1, iss_src2, iss_al_id, iss_payload,
               free_count
    );
endinterface

// File: rtl/iq_age_matrix.sv
// Age matrix plus oldest-eligible select. age_q[i][j]=1 means entry j is older
// than entry i; a freed entry's column is cleared so it never blocks anyone.
module iq_age_matrix #(
    parameter int DEPTH      = 8,
    parameter int DISPATCH_W = 2
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [DEPTH-1:0]                            valid_vec,
    input  logic [DISPATCH_W-1:0]                       ins_en,
    input  logic [DISPATCH_W-1:0][$clog2(DEPTH)-1:0]    ins_slot,
    input  logic [DEPTH-1:0]                            clr_vec,
    input  logic [DEPTH-1:0]                            eligible,
    output logic [DEPTH-1:0]                            grant
);
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_nxt;
    logic [DEPTH-1:0]            earlier;

    always_comb begin
        age_nxt = age_q;
        earlier = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (ins_en[k]) begin
                age_nxt[ins_slot[k]] = valid_vec | earlier;
                earlier[ins_slot[k]] = 1'b1;
            end
        end
        // Column clear wins over a same-cycle row set.
        for (int j = 0; j < DEPTH; j++) begin
            if (clr_vec[j]) begin
                for (int i = 0; i < DEPTH; i++) age_nxt[i][j] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            grant[i] = eligible[i] && ((age_q[i] & eligible) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) age_q <= '0;
        else        age_q <= age_nxt;
    end
endmodule

// File: rtl/priority_encoder.sv
// Lowest-index-first priority encoder.
module priority_encoder #(
    parameter int  N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/param_issue_queue.sv
// Out-of-order issue queue: compacting multi-lane dispatch, tag wakeup with
// dispatch bypass, and oldest-ready single issue per cycle.
module param_issue_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DISPATCH_W = 2,
    parameter int WB_PORTS   = 2,
    parameter int PAYLOAD_W  = 64
) (
    input logic               clk,
    input logic               rst_n,
    param_issue_queue_if.slave io
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    iq_entry_t [DEPTH-1:0]                ent_q, ent_nxt;
    logic [DEPTH-1:0][PAYLOAD_W-1:0]      pay_q;
    logic [CW-1:0]                        free_cnt_q, free_cnt_nxt;
    logic [DEPTH-1:0]                     valid_vec, eligible, grant, clr_vec;
    logic [DEPTH-1:0]                     avail [DISPATCH_W];
    logic [IW-1:0]                        free_slot [DISPATCH_W];
    logic [DISPATCH_W-1:0]                slot_found, ins_en;
    logic [DISPATCH_W-1:0][IW-1:0]        ins_slot;
    logic                                 disp_ready, disp_fire, iss_valid, iss_fire;
    iq_entry_t                            sel_ent;
    logic [PAYLOAD_W-1:0]                 sel_pay;

    function automatic logic wb_hit(input phys_tag_t t,
                                    input logic [WB_PORTS-1:0] v,
                                    input phys_tag_t [WB_PORTS-1:0] tags);
        wb_hit = 1'b0;
        for (int p = 0; p < WB_PORTS; p++)
            if (v[p] && tags[p] == t) wb_hit = 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            eligible[i]  = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
        end
    end

    // Successive free-slot searches, each masking the slot the previous one took.
    assign avail[0] = ~valid_vec;
    for (genvar g = 0; g < DISPATCH_W; g++) begin : g_alloc
        priority_encoder #(.N(DEPTH)) u_pe (
            .req(avail[g]), .idx(free_slot[g]), .found(slot_found[g])
        );
        if (g + 1 < DISPATCH_W) begin : g_mask
            assign avail[g+1] = avail[g] & ~(DEPTH'(1) << free_slot[g]);
        end
    end

    assign disp_ready = (free_cnt_q >= CW'(DISPATCH_W));
    assign disp_fire  = disp_ready && !io.flush;
    assign iss_valid  = (|eligible) && !io.flush;
    assign iss_fire   = iss_valid && io.iss_ready;
    assign clr_vec    = io.flush ? '1 : (iss_fire ? grant : '0);

    always_comb begin
        int rank;
        int cnt;
        ent_nxt  = ent_q;
        ins_en   = '0;
        ins_slot = '0;
        rank     = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
                if (wb_hit(ent_q[i].src1, io.wb_valid, io.wb_tag)) ent_nxt[i].src1_rdy = 1'b1;
                if (wb_hit(ent_q[i].src2, io.wb_valid, io.wb_tag)) ent_nxt[i].src2_rdy = 1'b1;
            end
            if (iss_fire && grant[i]) ent_nxt[i].valid = 1'b0;
        end
        // The n-th valid lane takes the n-th free slot, so gaps between lanes vanish.
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (disp_fire && io.disp_valid[k]) begin
                for (int r = 0; r < DISPATCH_W; r++) begin
                    if (r == rank && slot_found[r]) begin
                        ins_en[k]   = 1'b1;
                        ins_slot[k] = free_slot[r];
                    end
                end
                rank = rank + 1;
            end
        end
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (ins_en[k]) begin
                ent_nxt[ins_slot[k]].valid    = 1'b1;
                ent_nxt[ins_slot[k]].src1     = io.disp_src1[k];
                ent_nxt[ins_slot[k]].src2     = io.disp_src2[k];
                ent_nxt[ins_slot[k]].src1_rdy = io.disp_src1_rdy[k] |
                                                wb_hit(io.disp_src1[k], io.wb_valid, io.wb_tag);
                ent_nxt[ins_slot[k]].src2_rdy = io.disp_src2_rdy[k] |
                                                wb_hit(io.disp_src2[k], io.wb_valid, io.wb_tag);
                ent_nxt[ins_slot[k]].al_id    = io.disp_al_id[k];
            end
        end
        if (io.flush) begin
            for (int i = 0; i < DEPTH; i++) ent_nxt[i].valid = 1'b0;
        end
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) cnt = cnt + int'(ent_nxt[i].valid);
        free_cnt_nxt = CW'(DEPTH - cnt);
    end

    iq_age_matrix #(.DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W)) u_age (
        .clk(clk), .rst_n(rst_n), .valid_vec(valid_vec), .ins_en(ins_en),
        .ins_slot(ins_slot), .clr_vec(clr_vec), .eligible(eligible), .grant(grant)
    );

    // Grant is one-hot or zero, so an AND-OR mux yields zeros when nothing is eligible.
    always_comb begin
        sel_ent = '0;
        sel_pay = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_ent = iq_entry_t'(sel_ent | ent_q[i]);
                sel_pay = sel_pay | pay_q[i];
            end
        end
    end

    assign io.disp_ready  = disp_ready;
    assign io.free_count  = free_cnt_q;
    assign io.iss_valid   = iss_valid;
    assign io.iss_src1    = sel_ent.src1;
    assign io.iss_src2    = sel_ent.src2;
    assign io.iss_al_id   = sel_ent.al_id;
    assign io.iss_payload = sel_pay;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q      <= '0;
            pay_q      <= '0;
            free_cnt_q <= CW'(DEPTH);
        end else begin
            ent_q      <= ent_nxt;
            free_cnt_q <= free_cnt_nxt;
            for (int k = 0; k < DISPATCH_W; k++)
                if (ins_en[k]) pay_q[ins_slot[k]] <= io.disp_payload[k];
        end
    end
endmodule

// File: tb/tb_param_issue_queue.sv
// Bench for param_issue_queue: constant vector table, directed corner sequences,
// and random traffic checked against an in-order list model of the queue.
module tb_param_issue_queue;
    import mips_core_pkg::*;

    localparam int DEPTH      = 8;
    localparam int DISPATCH_W = 2;
    localparam int WB_PORTS   = 2;
    localparam int PAYLOAD_W  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    param_issue_queue_if #(.DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W),
                           .WB_PORTS(WB_PORTS), .PAYLOAD_W(PAYLOAD_W)) io ();

    param_issue_queue #(.DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W),
                        .WB_PORTS(WB_PORTS), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .rst_n(rst_n), .io(io)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: live entries kept oldest-first in a plain list.
    typedef struct {
        phys_tag_t            s1, s2;
        logic                 r1, r2;
        al_id_t               al;
        logic [PAYLOAD_W-1:0] pl;
    } m_ent_t;
    m_ent_t mq[$];

    function automatic logic m_hit(input phys_tag_t t);
        for (int p = 0; p < WB_PORTS; p++)
            if (io.wb_valid[p] && io.wb_tag[p] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_sel();
        foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
        return -1;
    endfunction

    task automatic check_model();
        int   sel;
        logic iv;
        sel = exp_sel();
        iv  = !io.flush && (sel >= 0);
        chk("m_iss_valid", 64'(io.iss_valid), 64'(iv));
        if (iv) begin
            chk("m_iss_al_id",   64'(io.iss_al_id),   64'(mq[sel].al));
            chk("m_iss_src1",    64'(io.iss_src1),    64'(mq[sel].s1));
            chk("m_iss_src2",    64'(io.iss_src2),    64'(mq[sel].s2));
            chk("m_iss_payload", io.iss_payload,      mq[sel].pl);
        end
        chk("m_free_count", 64'(io.free_count), 64'(DEPTH - mq.size()));
        chk("m_disp_ready", 64'(io.disp_ready), 64'((DEPTH - mq.size()) >= DISPATCH_W));
    endtask

    task automatic update_model();
        int     sel;
        logic   iv, dr;
        m_ent_t e;
        sel = exp_sel();
        iv  = !io.flush && (sel >= 0);
        dr  = (DEPTH - mq.size()) >= DISPATCH_W;
        if (io.flush) begin
            mq.delete();
        end else begin
            if (iv && io.iss_ready) mq.delete(sel);
            foreach (mq[i]) begin
                if (m_hit(mq[i].s1)) mq[i].r1 = 1'b1;
                if (m_hit(mq[i].s2)) mq[i].r2 = 1'b1;
            end
            if (dr) begin
                for (int k = 0; k < DISPATCH_W; k++) begin
                    if (io.disp_valid[k]) begin
                        e.s1 = io.disp_src1[k];
                        e.s2 = io.disp_src2[k];
                        e.r1 = io.disp_src1_rdy[k] | m_hit(e.s1);
                        e.r2 = io.disp_src2_rdy[k] | m_hit(e.s2);
                        e.al = io.disp_al_id[k];
                        e.pl = io.disp_payload[k];
                        mq.push_back(e);
                    end
                end
            end
        end
    endtask

    // Inputs are driven at posedge+1; outputs checked at posedge+3.
    task automatic tick();
        #2;
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic clear_in();
        io.disp_valid    = '0;
        io.disp_src1     = '0;
        io.disp_src2     = '0;
        io.disp_src1_rdy = '1;
        io.disp_src2_rdy = '1;
        io.disp_al_id    = '0;
        io.disp_payload  = '0;
        io.wb_valid      = '0;
        io.wb_tag        = '0;
        io.flush         = 1'b0;
        io.iss_ready     = 1'b0;
    endtask

    task automatic set_lane(input int k, input int s1, input int r1, input int s2,
                            input int r2, input int al);
        io.disp_valid[k]    = 1'b1;
        io.disp_src1[k]     = phys_tag_t'(s1);
        io.disp_src1_rdy[k] = (r1 != 0);
        io.disp_src2[k]     = phys_tag_t'(s2);
        io.disp_src2_rdy[k] = (r2 != 0);
        io.disp_al_id[k]    = al_id_t'(al);
        io.disp_payload[k]  = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        mq.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_free_count", 64'(io.free_count), 64'(DEPTH));
        chk("rst_disp_ready", 64'(io.disp_ready), 64'(1));
        chk("rst_iss_valid",  64'(io.iss_valid),  64'(0));
        chk("rst_iss_al_id",  64'(io.iss_al_id),  64'(0));
        chk("rst_iss_payload", io.iss_payload,    64'(0));
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] dv;
        logic [1:0] r1;
        logic       ir;
        logic       wb;
        phys_tag_t  wt;
        logic       e_iv;
        al_id_t     e_al;
        logic [3:0] e_fc;
        logic       e_dr;
    } vec_t;
    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        // Lane k of row r: src1=9+k, src2=20+k (ready), al_id=2r+k.
        tbl[0]  = '{2'b11, 2'b11, 1'b1, 1'b0, 6'd0,  1'b0, 5'd0,  4'd8, 1'b1};
        tbl[1]  = '{2'b00, 2'b11, 1'b1, 1'b0, 6'd0,  1'b1, 5'd0,  4'd6, 1'b1};
        tbl[2]  = '{2'b00, 2'b11, 1'b1, 1'b0, 6'd0,  1'b1, 5'd1,  4'd7, 1'b1};
        tbl[3]  = '{2'b01, 2'b00, 1'b0, 1'b1, 6'd9,  1'b0, 5'd0,  4'd8, 1'b1};
        tbl[4]  = '{2'b00, 2'b11, 1'b0, 1'b0, 6'd0,  1'b1, 5'd6,  4'd7, 1'b1};
        tbl[5]  = '{2'b00, 2'b11, 1'b0, 1'b0, 6'd0,  1'b1, 5'd6,  4'd7, 1'b1};
        tbl[6]  = '{2'b00, 2'b11, 1'b1, 1'b0, 6'd0,  1'b1, 5'd6,  4'd7, 1'b1};
        tbl[7]  = '{2'b10, 2'b00, 1'b1, 1'b0, 6'd0,  1'b0, 5'd0,  4'd8, 1'b1};
        tbl[8]  = '{2'b00, 2'b11, 1'b1, 1'b0, 6'd0,  1'b0, 5'd0,  4'd7, 1'b1};
        tbl[9]  = '{2'b00, 2'b11, 1'b1, 1'b1, 6'd10, 1'b0, 5'd0,  4'd7, 1'b1};
        tbl[10] = '{2'b00, 2'b11, 1'b1, 1'b0, 6'd0,  1'b1, 5'd15, 4'd7, 1'b1};
        tbl[11] = '{2'b00, 2'b11, 1'b0, 1'b0, 6'd0,  1'b0, 5'd0,  4'd8, 1'b1};

        do_reset();
        for (int r = 0; r < 12; r++) begin
            clear_in();
            for (int k = 0; k < DISPATCH_W; k++)
                if (tbl[r].dv[k]) set_lane(k, 9 + k, int'(tbl[r].r1[k]), 20 + k, 1, 2 * r + k);
            io.iss_ready   = tbl[r].ir;
            io.wb_valid[0] = tbl[r].wb;
            io.wb_tag[0]   = tbl[r].wt;
            #1;
            chk($sformatf("vec%0d_iss_valid", r), 64'(io.iss_valid), 64'(tbl[r].e_iv));
            if (tbl[r].e_iv)
                chk($sformatf("vec%0d_iss_al_id", r), 64'(io.iss_al_id), 64'(tbl[r].e_al));
            chk($sformatf("vec%0d_free_count", r), 64'(io.free_count), 64'(tbl[r].e_fc));
            chk($sformatf("vec%0d_disp_ready", r), 64'(io.disp_ready), 64'(tbl[r].e_dr));
            tick();
        end

        // Fill with a not-ready source, stall while full, then wake them all at once.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            clear_in();
            set_lane(0, 5, 0, 1, 1, 2 * c);
            set_lane(1, 5, 0, 2, 1, 2 * c + 1);
            tick();
        end
        clear_in();
        set_lane(0, 1, 1, 1, 1, 30);
        set_lane(1, 1, 1, 1, 1, 31);
        #1;
        chk("full_free_count", 64'(io.free_count), 64'(0));
        chk("full_disp_ready", 64'(io.disp_ready), 64'(0));
        chk("full_iss_valid",  64'(io.iss_valid),  64'(0));
        tick();
        clear_in();
        io.wb_valid[1] = 1'b1;
        io.wb_tag[1]   = 6'd5;
        tick();
        clear_in();
        io.iss_ready = 1'b1;
        #1;
        chk("wake_iss_valid", 64'(io.iss_valid), 64'(1));
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 8; cyc++) begin
            if (io.iss_valid) begin
                chk("wake_issue_order", 64'(io.iss_al_id), 64'(got));
                got++;
            end
            tick();
        end
        chk("wake_issue_count", 64'(got), 64'(8));

        // Slot 3 (older) and slot 1 (younger) both eligible; hold, then drain.
        do_reset();
        clear_in();
        set_lane(0, 1, 1, 2, 1, 0);
        set_lane(1, 1, 1, 2, 1, 1);
        tick();
        clear_in();
        set_lane(0, 40, 0, 2, 1, 2);
        set_lane(1, 41, 0, 2, 1, 3);
        io.iss_ready = 1'b1;
        tick();
        clear_in();
        io.iss_ready = 1'b1;
        tick();
        clear_in();
        set_lane(0, 42, 0, 2, 1, 8);
        set_lane(1, 1, 1, 2, 1, 9);
        io.wb_valid[0] = 1'b1;
        io.wb_tag[0]   = 6'd41;
        tick();
        for (int c = 0; c < 4; c++) begin
            clear_in();
            #1;
            chk("hold_iss_valid", 64'(io.iss_valid), 64'(1));
            chk("hold_iss_al_id", 64'(io.iss_al_id), 64'(3));
            tick();
        end
        clear_in();
        io.iss_ready = 1'b1;
        #1;
        chk("age_first",  64'(io.iss_al_id), 64'(3));
        tick();
        #1;
        chk("age_second", 64'(io.iss_al_id), 64'(9));
        tick();

        // Flush six live entries while a dispatch is offered.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            clear_in();
            set_lane(0, 1, 1, 2, 1, 2 * c);
            set_lane(1, 1, 1, 2, 1, 2 * c + 1);
            tick();
        end
        clear_in();
        set_lane(0, 1, 1, 2, 1, 20);
        set_lane(1, 1, 1, 2, 1, 21);
        io.flush     = 1'b1;
        io.iss_ready = 1'b1;
        #1;
        chk("flush_iss_valid", 64'(io.iss_valid), 64'(0));
        tick();
        clear_in();
        #1;
        chk("flush_free_count",   64'(io.free_count), 64'(DEPTH));
        chk("flush_no_survivor",  64'(io.iss_valid),  64'(0));
        tick();

        // Asynchronous reset between edges with a full queue.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            clear_in();
            set_lane(0, 1, 1, 2, 1, 2 * c + 1);
            set_lane(1, 1, 1, 2, 1, 2 * c + 2);
            tick();
        end
        clear_in();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_free_count", 64'(io.free_count), 64'(DEPTH));
        chk("arst_disp_ready", 64'(io.disp_ready), 64'(1));
        chk("arst_iss_valid",  64'(io.iss_valid),  64'(0));
        chk("arst_iss_al_id",  64'(io.iss_al_id),  64'(0));
        chk("arst_iss_payload", io.iss_payload,    64'(0));
        mq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic against the list model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            clear_in();
            for (int k = 0; k < DISPATCH_W; k++)
                if ($urandom_range(0, 1) == 1)
                    set_lane(k, $urandom_range(0, 7), int'($urandom_range(0, 3) == 0),
                             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31));
            for (int p = 0; p < WB_PORTS; p++) begin
                io.wb_valid[p] = ($urandom_range(0, 3) == 0);
                io.wb_tag[p]   = phys_tag_t'($urandom_range(0, 7));
            end
            io.iss_ready = ($urandom_range(0, 3) != 0);
            io.flush     = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
